// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - multi-cycle multiply/divide unit for the EX stage
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] opnd1_i,
    input  logic [XLEN-1:0] opnd2_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic            annul_i,
    output logic            stallreq_o,
    output logic            whilo_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);
    localparam int DW = 2 * XLEN;
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_ACC,
        S_DIV,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [DW-1:0]   r_prod;
    logic [DW-1:0]   r_res;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_in_div;
    logic            w_in_signed;
    logic [XLEN-1:0] w_abs1;
    logic [XLEN-1:0] w_abs2;
    logic [DW-1:0]   w_a_ext;
    logic [DW-1:0]   w_b_ext;
    logic [DW-1:0]   w_prod;
    logic [DW-1:0]   w_acc;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic            w_neg_q;
    logic            w_neg_r;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    // Acceptance and operand magnitudes for division, taken straight from the inputs
    assign w_accept    = start_i && !annul_i;
    assign w_in_div    = (op_i[2:1] == 2'b11);
    assign w_in_signed = !op_i[0];
    assign w_abs1      = (w_in_signed && opnd1_i[XLEN-1]) ? (~opnd1_i + 1'b1) : opnd1_i;
    assign w_abs2      = (w_in_signed && opnd2_i[XLEN-1]) ? (~opnd2_i + 1'b1) : opnd2_i;

    // Full-width product of the latched operands; low op bit selects zero extension
    assign w_a_ext = r_op[0] ? {{XLEN{1'b0}}, r_a} : {{XLEN{r_a[XLEN-1]}}, r_a};
    assign w_b_ext = r_op[0] ? {{XLEN{1'b0}}, r_b} : {{XLEN{r_b[XLEN-1]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign w_acc   = (r_op[2:1] == 2'b01) ? ({r_hi, r_lo} + r_prod) : ({r_hi, r_lo} - r_prod);

    // One restoring-division step: shift in the next dividend bit and try to subtract
    assign w_rem_sh = {r_rem, r_quo[XLEN-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = !w_diff[XLEN];
    assign w_rem_nx = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nx = {r_quo[XLEN-2:0], w_ge};

    // Sign fixup: quotient negative when signs differ, remainder follows the dividend
    assign w_neg_q   = !r_op[0] && (r_a[XLEN-1] ^ r_b[XLEN-1]);
    assign w_neg_r   = !r_op[0] && r_a[XLEN-1];
    assign w_quo_fix = w_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_rem_fix = w_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection and stall request; a flush always returns to IDLE
    always_comb begin
        w_next     = r_state;
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    stallreq_o = 1'b1;
                    if (w_in_div) begin
                        w_next = (opnd2_i == '0) ? S_DONE : S_DIV;
                    end else begin
                        w_next = S_MUL;
                    end
                end
            end
            S_MUL: begin
                stallreq_o = 1'b1;
                w_next     = (r_op[2:1] == 2'b00) ? S_DONE : S_ACC;
            end
            S_ACC: begin
                stallreq_o = 1'b1;
                w_next     = S_DONE;
            end
            S_DIV: begin
                stallreq_o = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (annul_i) begin
            w_next = S_IDLE;
        end
    end

    // Datapath: latch operands in IDLE, then advance multiply, accumulate or divide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_prod <= '0;
            r_res  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= op_i;
                        r_a   <= opnd1_i;
                        r_b   <= opnd2_i;
                        r_hi  <= hi_i;
                        r_lo  <= lo_i;
                        r_res <= '0;
                        r_quo <= w_abs1;
                        r_dvs <= w_abs2;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                S_MUL: begin
                    r_prod <= w_prod;
                    r_res  <= w_prod;
                end
                S_ACC: begin
                    r_res <= w_acc;
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_res <= {w_rem_fix, w_quo_fix};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result is only visible during DONE
    always_comb begin
        whilo_o = (r_state == S_DONE);
        hi_o    = whilo_o ? r_res[DW-1:XLEN] : '0;
        lo_o    = whilo_o ? r_res[XLEN-1:0] : '0;
    end
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - scoreboard testbench for ex_mdu
module tb_ex_mdu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] opnd1_i;
    logic [31:0] opnd2_i;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic        annul_i;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;

    ex_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opnd1_i(opnd1_i), .opnd2_i(opnd2_i), .hi_i(hi_i), .lo_i(lo_i),
        .annul_i(annul_i), .stallreq_o(stallreq_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    // Monitor: pop the scoreboard on every write pulse, outputs must be zero otherwise
    always @(negedge clk) begin
        if (!rst) begin
            if (whilo_o === 1'b1) begin
                exp_t e;
                pulses++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_whilo actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_hi"}, hi_o, e.hi);
                    check({e.name, "_lo"}, lo_o, e.lo);
                end
            end else begin
                checks++;
                if ((hi_o | lo_o) !== 32'h0) begin
                    failures++;
                    $display("FAIL idle_outputs actual=0x%08h_%08h required=0", hi_o, lo_o);
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                         input int exp_stall, input logic [31:0] eh, input logic [31:0] el);
        int n;
        exp_q.push_back('{name, eh, el});
        @(posedge clk);
        #1;
        start_i = 1'b1;
        op_i    = op;
        opnd1_i = a;
        opnd2_i = b;
        hi_i    = h;
        lo_i    = l;
        n = 0;
        @(negedge clk);
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            if (n > 1) begin
                opnd1_i = $urandom;
                opnd2_i = $urandom;
                hi_i    = $urandom;
                lo_i    = $urandom;
            end
            @(negedge clk);
        end
        check({name, "_stall_cycles"}, n, exp_stall);
        check({name, "_whilo"}, {31'b0, whilo_o}, 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    initial begin
        int p0;
        rst = 1'b1; start_i = 1'b0; op_i = 3'b000; annul_i = 1'b0;
        opnd1_i = '0; opnd2_i = '0; hi_i = '0; lo_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_stall", {31'b0, stallreq_o}, 32'd0);
        check("reset_whilo", {31'b0, whilo_o}, 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);

        do_op("mult",  3'b000, 32'hFFFFFFFF, 32'h2, 0, 0, 2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        do_op("multu", 3'b001, 32'hFFFFFFFF, 32'h2, 0, 0, 2, 32'h00000001, 32'hFFFFFFFE);
        do_op("maddu", 3'b011, 32'h1, 32'h1, 32'h0, 32'hFFFFFFFF, 3, 32'h00000001, 32'h0);
        do_op("msub",  3'b100, 32'h1, 32'h1, 32'h0, 32'h0, 3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("madd",  3'b010, 32'hFFFFFFFE, 32'h3, 32'h0, 32'h5, 3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("msubu", 3'b101, 32'h2, 32'h3, 32'h0, 32'hA, 3, 32'h0, 32'h4);
        do_op("div_neg", 3'b110, 32'hFFFFFFF9, 32'h2, 0, 0, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_negdvs", 3'b110, 32'h7, 32'hFFFFFFFE, 0, 0, 33, 32'h1, 32'hFFFFFFFD);
        do_op("divu", 3'b111, 32'd100, 32'd7, 0, 0, 33, 32'h2, 32'hE);
        do_op("div_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, 0, 33, 32'h0, 32'h80000000);
        do_op("divu_zero", 3'b111, 32'd5, 32'd0, 0, 0, 1, 32'h0, 32'h0);

        // Flush on the 10th divide cycle
        @(posedge clk);
        #1;
        start_i = 1'b1; op_i = 3'b111; opnd1_i = 32'd1000; opnd2_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1 annul_i = 1'b0;
        @(negedge clk);
        check("annul_stall", {31'b0, stallreq_o}, 32'd0);
        repeat (40) @(negedge clk);
        do_op("multu_after_annul", 3'b001, 32'd3, 32'd4, 0, 0, 2, 32'h0, 32'hC);

        // Reset during ACC
        @(posedge clk);
        #1;
        start_i = 1'b1; op_i = 3'b010; opnd1_i = 32'd1; opnd2_i = 32'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_acc_stall", {31'b0, stallreq_o}, 32'd0);
        check("rst_acc_whilo", {31'b0, whilo_o}, 32'd0);
        check("rst_acc_hi", hi_o, 32'd0);
        check("rst_acc_lo", lo_o, 32'd0);
        repeat (4) @(negedge clk);

        // Back-to-back MULTs with start held through DONE
        p0 = pulses;
        exp_q.push_back('{"b2b_first", 32'h0, 32'd15});
        exp_q.push_back('{"b2b_second", 32'hFFFFFFFF, 32'hFFFFFFF1});
        @(posedge clk);
        #1;
        start_i = 1'b1; op_i = 3'b000; opnd1_i = 32'd3; opnd2_i = 32'd5;
        @(posedge clk);
        @(posedge clk);
        #1;
        opnd1_i = 32'hFFFFFFFD; opnd2_i = 32'd5;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("b2b_pulses", pulses - p0, 32'd2);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
